// File: rtl/mouse_master_sm.sv
// PS/2 mouse master: power-up handshake (FF / FA AA 00 / F4 / FA), then 3-byte packet assembly.
// Optional build macro MOUSE_OVF_CLAMP_EN saturates DX/DY on the packet's overflow bits.
`timescale 1ns/1ps
module mouse_master_sm #(
    parameter int unsigned STARTUP_CYCLES       = 5000000,
    parameter int unsigned REPLY_TIMEOUT_CYCLES = 50000000,
    parameter int unsigned PKT_TIMEOUT_CYCLES   = 200000
) (
    input  logic       CLK,
    input  logic       RESET_N,
    output logic       SEND_BYTE,
    output logic [7:0] BYTE_TO_SEND,
    input  logic       BYTE_SENT,
    output logic       READ_ENABLE,
    input  logic [7:0] BYTE_READ,
    input  logic [1:0] BYTE_ERROR_CODE,
    input  logic       BYTE_READY,
    output logic [7:0] MOUSE_STATUS,
    output logic [7:0] MOUSE_DX,
    output logic [7:0] MOUSE_DY,
    output logic       SEND_INTERRUPT,
    output logic       INIT_DONE,
    output logic [3:0] debug_state
);

    typedef enum logic [3:0] {
        ST_STARTUP   = 4'd0,
        ST_SEND_RST  = 4'd1,
        ST_WAIT_TX1  = 4'd2,
        ST_WAIT_ACK1 = 4'd3,
        ST_WAIT_BAT  = 4'd4,
        ST_WAIT_ID   = 4'd5,
        ST_SEND_EN   = 4'd6,
        ST_WAIT_TX2  = 4'd7,
        ST_WAIT_ACK2 = 4'd8,
        ST_RX_STATUS = 4'd9,
        ST_RX_DX     = 4'd10,
        ST_RX_DY     = 4'd11,
        ST_PUBLISH   = 4'd12
    } state_t;

    state_t      state;
    logic [31:0] timer;
    logic [7:0]  status_sh;
    logic [7:0]  dx_sh;
    logic [7:0]  dy_sh;

    logic        byte_ok;
    logic        byte_bad;
    logic        reply_timeout;
    logic        pkt_timeout;
    logic        restart;
    logic [7:0]  reply_exp;
    state_t      reply_next;

    assign byte_ok       = BYTE_READY && (BYTE_ERROR_CODE == 2'b00);
    assign byte_bad      = BYTE_READY && (BYTE_ERROR_CODE != 2'b00);
    assign reply_timeout = (timer >= REPLY_TIMEOUT_CYCLES);
    assign pkt_timeout   = (timer >= PKT_TIMEOUT_CYCLES);
    assign debug_state   = state;

`ifdef MOUSE_OVF_CLAMP_EN
    function automatic logic [7:0] clamp_delta(input logic ovf, input logic sign,
                                               input logic [7:0] raw);
        if (!ovf)
            return raw;
        return sign ? 8'h80 : 8'h7F;
    endfunction
`endif

    // Handshake bookkeeping; a received byte always wins over a same-cycle timeout.
    always_comb begin
        reply_exp  = 8'h00;
        reply_next = ST_STARTUP;
        restart    = 1'b0;
        case (state)
            ST_WAIT_ACK1: begin reply_exp = 8'hFA; reply_next = ST_WAIT_BAT;  end
            ST_WAIT_BAT:  begin reply_exp = 8'hAA; reply_next = ST_WAIT_ID;   end
            ST_WAIT_ID:   begin reply_exp = 8'h00; reply_next = ST_SEND_EN;   end
            ST_WAIT_ACK2: begin reply_exp = 8'hFA; reply_next = ST_RX_STATUS; end
            default: ;
        endcase
        case (state)
            ST_WAIT_TX1, ST_WAIT_TX2:
                restart = !BYTE_SENT && (byte_bad || reply_timeout);
            ST_WAIT_ACK1, ST_WAIT_BAT, ST_WAIT_ID, ST_WAIT_ACK2:
                restart = BYTE_READY ? !(byte_ok && (BYTE_READ == reply_exp)) : reply_timeout;
            ST_STARTUP, ST_SEND_RST, ST_SEND_EN, ST_RX_STATUS, ST_RX_DX, ST_RX_DY, ST_PUBLISH:
                restart = 1'b0;
            default:
                restart = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state          <= ST_STARTUP;
            timer          <= '0;
            status_sh      <= '0;
            dx_sh          <= '0;
            dy_sh          <= '0;
            SEND_BYTE      <= 1'b0;
            BYTE_TO_SEND   <= '0;
            READ_ENABLE    <= 1'b0;
            MOUSE_STATUS   <= '0;
            MOUSE_DX       <= '0;
            MOUSE_DY       <= '0;
            SEND_INTERRUPT <= 1'b0;
            INIT_DONE      <= 1'b0;
        end else begin
            timer          <= timer + 32'd1;
            SEND_BYTE      <= 1'b0;
            SEND_INTERRUPT <= 1'b0;
            if (restart) begin
                state       <= ST_STARTUP;
                timer       <= '0;
                READ_ENABLE <= 1'b0;
                INIT_DONE   <= 1'b0;
            end else begin
                case (state)
                    ST_STARTUP: begin
                        if (timer + 32'd1 >= STARTUP_CYCLES) begin
                            state <= ST_SEND_RST;
                            timer <= '0;
                        end
                    end
                    ST_SEND_RST: begin
                        SEND_BYTE    <= 1'b1;
                        BYTE_TO_SEND <= 8'hFF;
                        READ_ENABLE  <= 1'b1;
                        state        <= ST_WAIT_TX1;
                        timer        <= '0;
                    end
                    ST_WAIT_TX1, ST_WAIT_TX2: begin
                        if (BYTE_SENT) begin
                            state <= (state == ST_WAIT_TX1) ? ST_WAIT_ACK1 : ST_WAIT_ACK2;
                            timer <= '0;
                        end
                    end
                    ST_WAIT_ACK1, ST_WAIT_BAT, ST_WAIT_ID, ST_WAIT_ACK2: begin
                        // Reaching here with BYTE_READY means the reply matched.
                        if (BYTE_READY) begin
                            state       <= reply_next;
                            timer       <= '0;
                            READ_ENABLE <= (reply_next != ST_SEND_EN);
                            if (state == ST_WAIT_ACK2)
                                INIT_DONE <= 1'b1;
                        end
                    end
                    ST_SEND_EN: begin
                        SEND_BYTE    <= 1'b1;
                        BYTE_TO_SEND <= 8'hF4;
                        READ_ENABLE  <= 1'b1;
                        state        <= ST_WAIT_TX2;
                        timer        <= '0;
                    end
                    ST_RX_STATUS: begin
                        // Bytes without the always-one bit3 cannot start a packet.
                        if (byte_ok && BYTE_READ[3]) begin
                            status_sh <= BYTE_READ;
                            state     <= ST_RX_DX;
                            timer     <= '0;
                        end
                    end
                    ST_RX_DX: begin
                        if (byte_ok) begin
                            dx_sh <= BYTE_READ;
                            state <= ST_RX_DY;
                            timer <= '0;
                        end else if (byte_bad || pkt_timeout) begin
                            state <= ST_RX_STATUS;
                            timer <= '0;
                        end
                    end
                    ST_RX_DY: begin
                        if (byte_ok) begin
                            dy_sh       <= BYTE_READ;
                            state       <= ST_PUBLISH;
                            READ_ENABLE <= 1'b0;
                            timer       <= '0;
                        end else if (byte_bad || pkt_timeout) begin
                            state <= ST_RX_STATUS;
                            timer <= '0;
                        end
                    end
                    ST_PUBLISH: begin
                        MOUSE_STATUS   <= status_sh;
`ifdef MOUSE_OVF_CLAMP_EN
                        MOUSE_DX       <= clamp_delta(status_sh[6], status_sh[4], dx_sh);
                        MOUSE_DY       <= clamp_delta(status_sh[7], status_sh[5], dy_sh);
`else
                        MOUSE_DX       <= dx_sh;
                        MOUSE_DY       <= dy_sh;
`endif
                        SEND_INTERRUPT <= 1'b1;
                        READ_ENABLE    <= 1'b1;
                        state          <= ST_RX_STATUS;
                        timer          <= '0;
                    end
                    default: begin
                        state <= ST_STARTUP;
                        timer <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mouse_master_sm.sv
// Scoreboard bench for mouse_master_sm: a device model answers the handshake and a
// packet-level reference model predicts every published packet and its interrupt cycle.
`timescale 1ns/1ps
module tb_mouse_master_sm;

    localparam int STARTUP = 50;
    localparam int REPLY_TO = 400;
    localparam int PKT_TO = 60;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       SEND_BYTE;
    logic [7:0] BYTE_TO_SEND;
    logic       BYTE_SENT = 1'b0;
    logic       READ_ENABLE;
    logic [7:0] BYTE_READ = 8'h00;
    logic [1:0] BYTE_ERROR_CODE = 2'b00;
    logic       BYTE_READY = 1'b0;
    logic [7:0] MOUSE_STATUS;
    logic [7:0] MOUSE_DX;
    logic [7:0] MOUSE_DY;
    logic       SEND_INTERRUPT;
    logic       INIT_DONE;
    logic [3:0] debug_state;

    mouse_master_sm #(
        .STARTUP_CYCLES(STARTUP),
        .REPLY_TIMEOUT_CYCLES(REPLY_TO),
        .PKT_TIMEOUT_CYCLES(PKT_TO)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .SEND_BYTE(SEND_BYTE), .BYTE_TO_SEND(BYTE_TO_SEND),
        .BYTE_SENT(BYTE_SENT), .READ_ENABLE(READ_ENABLE), .BYTE_READ(BYTE_READ),
        .BYTE_ERROR_CODE(BYTE_ERROR_CODE), .BYTE_READY(BYTE_READY),
        .MOUSE_STATUS(MOUSE_STATUS), .MOUSE_DX(MOUSE_DX), .MOUSE_DY(MOUSE_DY),
        .SEND_INTERRUPT(SEND_INTERRUPT), .INIT_DONE(INIT_DONE), .debug_state(debug_state)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    int checks = 0;
    int failures = 0;
    logic [7:0]  send_q[$];              // expected command bytes
    logic [55:0] exp_q[$];               // {interrupt cycle, status, dx, dy}
    logic [23:0] last_pub = 24'h0;       // outputs must hold this between interrupts
    int sent_cnt = 0;
    int sent_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // monitor
    always @(negedge CLK) begin
        if (RESET_N && SEND_BYTE === 1'b1) begin
            sent_cnt++;
            sent_cyc = cyc;
            if (send_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_send: got %0h expected no command", BYTE_TO_SEND);
            end else begin
                check("send_byte", {24'h0, BYTE_TO_SEND}, {24'h0, send_q.pop_front()});
            end
        end
        if (RESET_N && SEND_INTERRUPT === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_irq: got %0h/%0h/%0h expected no packet",
                         MOUSE_STATUS, MOUSE_DX, MOUSE_DY);
            end else begin
                logic [55:0] e;
                e = exp_q.pop_front();
                check("irq_cycle", cyc, e[55:24]);
                check("pkt_status", {24'h0, MOUSE_STATUS}, {24'h0, e[23:16]});
                check("pkt_dx", {24'h0, MOUSE_DX}, {24'h0, e[15:8]});
                check("pkt_dy", {24'h0, MOUSE_DY}, {24'h0, e[7:0]});
                last_pub = e[23:0];
            end
        end else begin
            check("outputs_hold", {8'h0, MOUSE_STATUS, MOUSE_DX, MOUSE_DY}, {8'h0, last_pub});
        end
    end

    // ---------------- reference model ----------------
    int m_idx = 0;
    logic [7:0] m_st = 8'h0;
    logic [7:0] m_dx = 8'h0;

    function automatic logic [7:0] model_clamp(input logic ovf, input logic sign, input logic [7:0] raw);
`ifdef MOUSE_OVF_CLAMP_EN
        if (ovf) return sign ? 8'h80 : 8'h7F;
`endif
        return raw;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic rx(input logic [7:0] b, input logic [1:0] err);
        BYTE_READ = b;
        BYTE_ERROR_CODE = err;
        BYTE_READY = 1'b1;
        @(negedge CLK);
        BYTE_READY = 1'b0;
        BYTE_ERROR_CODE = 2'b00;
    endtask

    task automatic tx_ack();
        idle(3);
        BYTE_SENT = 1'b1;
        @(negedge CLK);
        BYTE_SENT = 1'b0;
    endtask

    task automatic wait_sent(input int prev, input int bound, input string name);
        int k = 0;
        while (sent_cnt == prev && k < bound) begin
            @(negedge CLK);
            k++;
        end
        checks++;
        if (sent_cnt == prev) begin
            failures++;
            $display("FAIL %s: got no command within %0d cycles expected one", name, bound);
        end
    endtask

    // Everything after the reset command has gone out.
    task automatic finish_handshake();
        int p;
        tx_ack();
        idle(3); rx(8'hFA, 2'b00);
        idle(4); rx(8'hAA, 2'b00);
        idle(4);
        p = sent_cnt;
        send_q.push_back(8'hF4);
        rx(8'h00, 2'b00);
        wait_sent(p, 20, "wait_f4");
        tx_ack();
        idle(3); rx(8'hFA, 2'b00);
        idle(2);
        check("init_done", {31'h0, INIT_DONE}, 32'h1);
        check("read_enable_stream", {31'h0, READ_ENABLE}, 32'h1);
    endtask

    task automatic handshake();
        int p = sent_cnt;
        send_q.push_back(8'hFF);
        wait_sent(p, STARTUP + 20, "wait_ff");
        finish_handshake();
    endtask

    // gap = idle cycles since the previous strobe; packets drop when gap exceeds PKT_TO.
    task automatic stream(input logic [7:0] b, input logic [1:0] err, input int gap);
        idle(gap);
        if (m_idx > 0 && gap > PKT_TO) m_idx = 0;
        case (m_idx)
            0: if (err == 2'b00 && b[3]) begin m_st = b; m_idx = 1; end
            1: if (err != 2'b00) m_idx = 0; else begin m_dx = b; m_idx = 2; end
            default: begin
                if (err == 2'b00)
                    exp_q.push_back({32'(cyc + 2), m_st,
                                     model_clamp(m_st[6], m_st[4], m_dx),
                                     model_clamp(m_st[7], m_st[5], b)});
                m_idx = 0;
            end
        endcase
        rx(b, err);
    endtask

    task automatic check_outputs(input string name, input logic [23:0] exp);
        check(name, {8'h0, MOUSE_STATUS, MOUSE_DX, MOUSE_DY}, {8'h0, exp});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int p;
        int fail_cyc;
        logic [7:0] exp_dx;

        idle(3);
        check("rst_send_byte", {31'h0, SEND_BYTE}, 32'h0);
        check("rst_byte_to_send", {24'h0, BYTE_TO_SEND}, 32'h0);
        check("rst_read_enable", {31'h0, READ_ENABLE}, 32'h0);
        check("rst_init_done", {31'h0, INIT_DONE}, 32'h0);
        check("rst_irq", {31'h0, SEND_INTERRUPT}, 32'h0);
        check_outputs("rst_outputs", 24'h0);
        RESET_N = 1'b1;

        // Self-test failure reply: a fresh reset command must follow after the startup wait.
        p = sent_cnt;
        send_q.push_back(8'hFF);
        wait_sent(p, STARTUP + 20, "wait_ff_first");
        tx_ack();
        idle(3); rx(8'hFA, 2'b00);
        idle(4);
        p = sent_cnt;
        send_q.push_back(8'hFF);
        fail_cyc = cyc;
        rx(8'hFC, 2'b00);
        idle(2);
        check("init_done_after_fc", {31'h0, INIT_DONE}, 32'h0);
        wait_sent(p, STARTUP + 20, "wait_ff_retry");
        check("retry_gap_in_window",
              {31'h0, (sent_cyc - fail_cyc >= STARTUP) && (sent_cyc - fail_cyc <= STARTUP + 4)}, 32'h1);
        finish_handshake();
        check_outputs("outputs_zero_after_init", 24'h0);

        // Directed packets.
        stream(8'h08, 2'b00, 5); stream(8'h05, 2'b00, 4); stream(8'hFB, 2'b00, 4);
        idle(4); check_outputs("pkt_basic", 24'h0805FB);
        stream(8'h00, 2'b00, 5); stream(8'h09, 2'b00, 4);
        stream(8'h10, 2'b00, 4); stream(8'h20, 2'b00, 4);
        idle(4); check_outputs("pkt_resync", 24'h091020);
        stream(8'h08, 2'b00, 5); stream(8'h05, 2'b01, 4);
        stream(8'h08, 2'b00, 4); stream(8'h01, 2'b00, 4); stream(8'h02, 2'b00, 4);
        idle(4); check_outputs("pkt_midfault", 24'h080102);
        stream(8'h08, 2'b00, 5); stream(8'h05, 2'b00, 4);
        stream(8'h18, 2'b00, PKT_TO + 20); stream(8'hFF, 2'b00, 4); stream(8'h01, 2'b00, 4);
        idle(4); check_outputs("pkt_timeout", 24'h18FF01);
        stream(8'h58, 2'b00, 5); stream(8'h12, 2'b00, 4); stream(8'h34, 2'b00, 4);
        idle(4);
`ifdef MOUSE_OVF_CLAMP_EN
        exp_dx = 8'h80;
`else
        exp_dx = 8'h12;
`endif
        check("pkt_clamp_dx", {24'h0, MOUSE_DX}, {24'h0, exp_dx});

        // Randomized stream with errors, resync bytes and long gaps.
        for (int i = 0; i < 60; i++) begin
            logic [7:0] b;
            logic [1:0] err;
            int gap;
            b = 8'($urandom_range(0, 255));
            if (m_idx == 0 && $urandom_range(0, 3) != 0) b[3] = 1'b1;
            err = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            gap = ($urandom_range(0, 7) == 0) ? PKT_TO + int'($urandom_range(5, 30))
                                              : int'($urandom_range(2, 10));
            stream(b, err, gap);
        end
        idle(6);

        // Reset between packet bytes 1 and 2.
        stream(8'h08, 2'b00, 5);
        idle(2);
        #2 RESET_N = 1'b0;
        last_pub = 24'h0;
        m_idx = 0;
        #1;
        check_outputs("midpkt_reset_outputs", 24'h0);
        check("midpkt_reset_init_done", {31'h0, INIT_DONE}, 32'h0);
        check("midpkt_reset_read_enable", {31'h0, READ_ENABLE}, 32'h0);
        idle(3);
        RESET_N = 1'b1;
        handshake();
        stream(8'h28, 2'b00, 5); stream(8'h03, 2'b00, 4); stream(8'h04, 2'b00, 4);
        idle(6);
        check_outputs("pkt_after_reset", 24'h280304);

        idle(10);
        check("irq_queue_drained", exp_q.size(), 32'h0);
        check("send_queue_drained", send_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute guard so the run always ends.
    initial begin
        #2000000;
        $display("FAIL global_timeout: got no end of stimulus expected completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "bench timeout");
    end

endmodule
